// File: rtl/sram_bank_pkg.sv
// Shared definitions for the multi-port SRAM bank: default Bennett phase
// placement, sequencer state encoding and the registered op record.
package sram_bank_pkg;

    // Default phase placement inside one adiabatic cycle
    localparam int DEF_PHASES  = 10;
    localparam int DEF_ADDR_PH = 2;
    localparam int DEF_RD_PH   = 6;
    localparam int DEF_WR_PH   = 8;

    // Widest address/data the op record can carry; wider instances are rejected
    localparam int MAX_AW    = 16;
    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_RUN  = 1'b1
    } ph_state_t;

    // Op fields held stable for the whole Bennett cycle; narrower instances
    // zero-extend into these fields
    typedef struct packed {
        logic                 rd;
        logic                 wr;
        logic [MAX_AW-1:0]    wr_addr;
        logic [MAX_WIDTH-1:0] wr_data;
    } sram_op_t;

endpackage

// File: rtl/bennett_phase_gen.sv
// Bennett phase sequencer: IDLE/RUN FSM stepping a one-hot phase through
// PHASES clocks per accepted op, with back-to-back restart from the last phase.
module bennett_phase_gen
    import sram_bank_pkg::*;
#(
    parameter  int PHASES = DEF_PHASES,
    localparam int PW     = $clog2(PHASES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    output logic              running,
    output logic [PW-1:0]     phIdx,
    output logic [PHASES-1:0] phase,
    output logic              lastPh
);

    ph_state_t state;

    assign running = (state == PH_RUN);

    // Sequencer FSM: all outputs registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PH_IDLE;
            phIdx  <= '0;
            phase  <= '0;
            lastPh <= 1'b0;
        end else begin
            case (state)
                PH_IDLE: begin
                    if (accept) begin
                        state  <= PH_RUN;
                        phIdx  <= '0;
                        phase  <= PHASES'(1);
                        lastPh <= 1'b0;
                    end
                end
                PH_RUN: begin
                    if (phIdx == PW'(PHASES - 1)) begin
                        if (accept) begin
                            // Back-to-back issue: restart without an idle gap
                            phIdx  <= '0;
                            phase  <= PHASES'(1);
                            lastPh <= 1'b0;
                        end else begin
                            state  <= PH_IDLE;
                            phIdx  <= '0;
                            phase  <= '0;
                            lastPh <= 1'b0;
                        end
                    end else begin
                        phIdx  <= phIdx + PW'(1);
                        phase  <= phase << 1;
                        lastPh <= (phIdx == PW'(PHASES - 2));
                    end
                end
                default: begin
                    state  <= PH_IDLE;
                    phIdx  <= '0;
                    phase  <= '0;
                    lastPh <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_mport_bank.sv
// Multi-read-port SRAM bank driven by its own Bennett phase sequencer.
// Each op decodes to one-hot wordlines, senses at RD_PH, commits at WR_PH.
module sram_mport_bank
    import sram_bank_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 32,
    parameter  int RD_PORTS = 2,
    parameter  int PHASES   = DEF_PHASES,
    parameter  int ADDR_PH  = DEF_ADDR_PH,
    parameter  int RD_PH    = DEF_RD_PH,
    parameter  int WR_PH    = DEF_WR_PH,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic                      op_rd,
    input  logic                      op_wr,
    input  logic [RD_PORTS*AW-1:0]    rd_addr,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [RD_PORTS*WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    output logic [PHASES-1:0]         phase,
    output logic [RD_PORTS*DEPTH-1:0] wl_rd,
    output logic [DEPTH-1:0]          wl_wr,
    output logic                      srclk_null,
    output logic                      addr_err
);

    localparam int PW = $clog2(PHASES);

    if (!(ADDR_PH < RD_PH && RD_PH < WR_PH && WR_PH < PHASES)) begin : gBadPhaseOrder
        $error("sram_mport_bank: need ADDR_PH < RD_PH < WR_PH < PHASES");
    end
    if (AW > MAX_AW || WIDTH > MAX_WIDTH || RD_PORTS < 1) begin : gBadSize
        $error("sram_mport_bank: DEPTH/WIDTH/RD_PORTS outside supported range");
    end

    logic          running;
    logic          lastPh;
    logic [PW-1:0] phIdx;
    logic          accept;

    bennett_phase_gen #(.PHASES(PHASES)) uPhaseGen (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .running (running),
        .phIdx   (phIdx),
        .phase   (phase),
        .lastPh  (lastPh)
    );

    assign op_ready = !running || lastPh;
    assign accept   = op_valid && op_ready;

    sram_op_t                opReg;
    logic [RD_PORTS*AW-1:0]  rdAddrReg;

    // Capture op fields at accept; they stay put for the whole cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opReg     <= '0;
            rdAddrReg <= '0;
        end else if (accept) begin
            opReg.rd      <= op_rd;
            opReg.wr      <= op_wr;
            opReg.wr_addr <= MAX_AW'(wr_addr);
            opReg.wr_data <= MAX_WIDTH'(wr_data);
            rdAddrReg     <= rd_addr;
        end
    end

    logic [MAX_AW-1:0]    wrAddrFull;
    logic [MAX_WIDTH-1:0] wrDataFull;
    logic [AW-1:0]        wrAddr;
    logic [WIDTH-1:0]     wrData;
    logic                 wrInRange;
    logic                 wlActive;
    logic                 rdSample;
    logic                 wrCommit;
    logic [RD_PORTS-1:0]  rdBad;

    assign wrAddrFull = opReg.wr_addr;
    assign wrDataFull = opReg.wr_data;
    assign wrAddr     = AW'(wrAddrFull);
    assign wrData     = WIDTH'(wrDataFull);
    assign wrInRange  = (wrAddrFull < MAX_AW'(DEPTH));

    // Wordlines stay up from ADDR_PH to the end of the cycle
    assign wlActive = running && (phIdx >= PW'(ADDR_PH));
    assign rdSample = running && (phIdx == PW'(RD_PH)) && opReg.rd;
    // Reset drops running, so an aborted op can never reach the commit edge
    assign wrCommit = running && (phIdx == PW'(WR_PH)) && opReg.wr && wrInRange;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: cleared by reset, written on the edge ending WR_PH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrCommit) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Write decoder: out-of-range addresses match no wordline
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gWlWr
        assign wl_wr[gi] = wlActive && opReg.wr && (wrAddrFull == MAX_AW'(gi));
    end

    for (genvar gp = 0; gp < RD_PORTS; gp++) begin : gRdPort
        logic [AW-1:0]    rdAddr;
        logic             rdInRange;
        logic             bypassHit;
        logic [WIDTH-1:0] rdWord;
        logic [WIDTH-1:0] rdDataReg;

        assign rdAddr    = rdAddrReg[gp*AW +: AW];
        assign rdInRange = ({1'b0, rdAddr} < (AW+1)'(DEPTH));
        assign rdBad[gp] = !rdInRange;
        assign bypassHit = (BYPASS != 0) && opReg.wr && (rdAddr == wrAddr);
        assign rdWord    = !rdInRange ? '0 :
                           bypassHit  ? wrData : mem[rdAddr];

        for (genvar gi = 0; gi < DEPTH; gi++) begin : gWlRd
            assign wl_rd[gp*DEPTH + gi] = wlActive && opReg.rd && (rdAddr == AW'(gi));
        end

        // Sense register: loads at RD_PH, holds until the next read
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdDataReg <= '0;
            end else if (rdSample) begin
                rdDataReg <= rdWord;
            end
        end

        assign rd_data[gp*WIDTH +: WIDTH] = rdDataReg;
    end

    logic rdValidReg;

    // rd_valid pulses in the phase right after the sense edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValidReg <= 1'b0;
        end else begin
            rdValidReg <= rdSample;
        end
    end

    assign rd_valid   = rdValidReg;
    assign srclk_null = running && opReg.rd && (phIdx > PW'(RD_PH));
    assign addr_err   = running && (phIdx == PW'(ADDR_PH)) &&
                        ((opReg.rd && (|rdBad)) || (opReg.wr && !wrInRange));

endmodule

// File: tb/tb_sram_mport_bank.sv
// Directed bench: dutA uses defaults (2 ports, DEPTH 32, bypass on),
// dutB uses 4 ports, DEPTH 20, bypass off.
module tb_sram_mport_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dutA signals
    logic        rstA, vA, rdA, wrA, readyA, rvA, nullA, errA;
    logic [9:0]  raA;
    logic [4:0]  waA;
    logic [15:0] wdA;
    logic [31:0] rdDataA;
    logic [9:0]  phA;
    logic [63:0] wlRdA;
    logic [31:0] wlWrA;

    // dutB signals
    logic        rstB, vB, rdB, wrB, readyB, rvB, nullB, errB;
    logic [19:0] raB;
    logic [4:0]  waB;
    logic [15:0] wdB;
    logic [63:0] rdDataB;
    logic [9:0]  phB;
    logic [79:0] wlRdB;
    logic [19:0] wlWrB;

    sram_mport_bank dutA (
        .clk(clk), .reset(rstA), .op_valid(vA), .op_ready(readyA),
        .op_rd(rdA), .op_wr(wrA), .rd_addr(raA), .wr_addr(waA), .wr_data(wdA),
        .rd_data(rdDataA), .rd_valid(rvA), .phase(phA), .wl_rd(wlRdA),
        .wl_wr(wlWrA), .srclk_null(nullA), .addr_err(errA)
    );

    sram_mport_bank #(.DEPTH(20), .RD_PORTS(4), .BYPASS(0)) dutB (
        .clk(clk), .reset(rstB), .op_valid(vB), .op_ready(readyB),
        .op_rd(rdB), .op_wr(wrB), .rd_addr(raB), .wr_addr(waB), .wr_data(wdB),
        .rd_data(rdDataB), .rd_valid(rvB), .phase(phB), .wl_rd(wlRdB),
        .wl_wr(wlWrB), .srclk_null(nullB), .addr_err(errB)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns at the negedge inside phase 0 of the accepted op
    task automatic issueA(input logic r, input logic w, input logic [9:0] ra,
                          input logic [4:0] wa, input logic [15:0] wd);
        int n = 0;
        @(negedge clk);
        while (!readyA && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("A_ready_wait", readyA, 1'b1);
        rdA = r; wrA = w; raA = ra; waA = wa; wdA = wd; vA = 1'b1;
        @(negedge clk);
        vA = 1'b0;
        $display("A op rd=%0b wr=%0b rd_addr=%h wr_addr=%0d wr_data=%h", r, w, ra, wa, wd);
    endtask

    task automatic issueB(input logic r, input logic w, input logic [19:0] ra,
                          input logic [4:0] wa, input logic [15:0] wd);
        int n = 0;
        @(negedge clk);
        while (!readyB && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("B_ready_wait", readyB, 1'b1);
        rdB = r; wrB = w; raB = ra; waB = wa; wdB = wd; vB = 1'b1;
        @(negedge clk);
        vB = 1'b0;
        $display("B op rd=%0b wr=%0b rd_addr=%h wr_addr=%0d wr_data=%h", r, w, ra, wa, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] expWlA;
        logic [79:0] expWlB;
        logic [15:0] dataTbl [4];
        int n;

        dataTbl[0] = 16'hA0A0; dataTbl[1] = 16'hB1B1;
        dataTbl[2] = 16'hC2C2; dataTbl[3] = 16'hD3D3;

        rstA = 1'b1; vA = 1'b0; rdA = 1'b0; wrA = 1'b0; raA = '0; waA = '0; wdA = '0;
        rstB = 1'b1; vB = 1'b0; rdB = 1'b0; wrB = 1'b0; raB = '0; waB = '0; wdB = '0;
        step(2);

        // Reset state
        chk("A_rst_ready", readyA, 1'b1);
        chk("A_rst_phase", phA, 10'd0);
        chk("A_rst_rd_data", rdDataA, 32'd0);
        chk("A_rst_rd_valid", rvA, 1'b0);
        chk("A_rst_wl", {wlRdA, wlWrA}, 96'd0);
        chk("A_rst_null_err", {nullA, errA}, 2'b00);
        chk("B_rst_ready", readyB, 1'b1);
        chk("B_rst_phase", phB, 10'd0);
        rstA = 1'b0;
        rstB = 1'b0;

        // Two writes then a two-port read
        issueA(1'b0, 1'b1, 10'd0, 5'd1, 16'hAAAA);
        issueA(1'b0, 1'b1, 10'd0, 5'd0, 16'hABCD);
        issueA(1'b1, 1'b0, {5'd0, 5'd1}, 5'd0, 16'h0000);
        expWlA = (64'd1 << 1) | (64'd1 << 32);
        for (int ph = 1; ph <= 9; ph++) begin
            @(negedge clk);
            chk("A_phase", phA, 10'b1 << ph);
            chk("A_rd_valid", rvA, ph == 7);
            chk("A_srclk_null", nullA, ph >= 7);
            chk("A_ready_phase", readyA, ph == 9);
            if (ph == 1) chk("A_wl_rd_pre", wlRdA, 64'd0);
            if (ph == 2) chk("A_wl_rd", wlRdA, expWlA);
            if (ph == 2) chk("A_addr_err_ok", errA, 1'b0);
            if (ph == 7) chk("A_rd_data", rdDataA, 32'hABCD_AAAA);
        end

        // Same-op read+write with bypass enabled
        issueA(1'b0, 1'b1, 10'd0, 5'd5, 16'h1111);
        issueA(1'b1, 1'b1, {5'd5, 5'd5}, 5'd5, 16'h2222);
        step(7);
        chk("A_bypass_valid", rvA, 1'b1);
        chk("A_bypass_data", rdDataA, 32'h2222_2222);
        issueA(1'b1, 1'b0, {5'd5, 5'd5}, 5'd0, 16'h0000);
        step(7);
        chk("A_after_bypass", rdDataA, 32'h2222_2222);

        // Reset in the write-commit phase aborts the write
        issueA(1'b0, 1'b1, 10'd0, 5'd3, 16'hBEEF);
        step(8);
        chk("A_wr_phase8", phA, 10'b1 << 8);
        chk("A_wl_wr", wlWrA, 32'd1 << 3);
        rstA = 1'b1;
        #1;
        chk("A_midrst_phase", phA, 10'd0);
        chk("A_midrst_wl_wr", wlWrA, 32'd0);
        chk("A_midrst_ready", readyA, 1'b1);
        chk("A_midrst_rd_data", rdDataA, 32'd0);
        #2;
        rstA = 1'b0;
        issueA(1'b1, 1'b0, {5'd1, 5'd3}, 5'd0, 16'h0000);
        step(7);
        chk("A_postrst_valid", rvA, 1'b1);
        chk("A_postrst_data", rdDataA, 32'd0);

        // Three back-to-back no-op accepts with op_valid held high
        n = 0;
        @(negedge clk);
        while (!readyA && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("A_b2b_ready_wait", readyA, 1'b1);
        rdA = 1'b0; wrA = 1'b0; vA = 1'b1;
        $display("A op b2b x3 no-op");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("A_b2b_phase", phA, 10'b1 << (i % 10));
            chk("A_b2b_ready", readyA, (i % 10) == 9);
            if ((i % 10) == 2) chk("A_b2b_wl", {wlRdA, wlWrA}, 96'd0);
            if ((i % 10) == 7) chk("A_b2b_rv", rvA, 1'b0);
            if (i == 20) vA = 1'b0;
        end
        @(negedge clk);
        chk("A_b2b_idle_phase", phA, 10'd0);
        chk("A_b2b_idle_ready", readyA, 1'b1);

        // dutB: bypass disabled returns old data
        issueB(1'b0, 1'b1, 20'd0, 5'd5, 16'h1111);
        issueB(1'b1, 1'b1, {5'd5, 5'd5, 5'd5, 5'd5}, 5'd5, 16'h2222);
        step(7);
        chk("B_nobypass_valid", rvB, 1'b1);
        chk("B_nobypass_data", rdDataB, 64'h1111_1111_1111_1111);
        issueB(1'b1, 1'b0, {5'd5, 5'd5, 5'd5, 5'd5}, 5'd0, 16'h0000);
        step(7);
        chk("B_after_write", rdDataB, 64'h2222_2222_2222_2222);

        // Out-of-range write is flagged and dropped
        issueB(1'b0, 1'b1, 20'd0, 5'd25, 16'h5555);
        step(1);
        chk("B_err_ph1", errB, 1'b0);
        step(1);
        chk("B_err_ph2", errB, 1'b1);
        chk("B_oor_wl_wr", wlWrB, 20'd0);
        step(1);
        chk("B_err_ph3", errB, 1'b0);

        // Out-of-range read on port 0
        issueB(1'b1, 1'b0, {5'd5, 5'd5, 5'd5, 5'd25}, 5'd0, 16'h0000);
        step(2);
        expWlB = (80'd1 << 25) | (80'd1 << 45) | (80'd1 << 65);
        chk("B_rd_err", errB, 1'b1);
        chk("B_oor_wl_rd", wlRdB, expWlB);
        step(5);
        chk("B_oor_rd_data", rdDataB, 64'h2222_2222_2222_0000);

        // Four ports reading distinct addresses
        for (int i = 0; i < 4; i++) begin
            issueB(1'b0, 1'b1, 20'd0, 5'(i), dataTbl[i]);
        end
        issueB(1'b1, 1'b0, {5'd3, 5'd2, 5'd1, 5'd0}, 5'd0, 16'h0000);
        for (int ph = 1; ph <= 9; ph++) begin
            @(negedge clk);
            chk("B_phase", phB, 10'b1 << ph);
            chk("B_srclk_null", nullB, ph >= 7);
            chk("B_rd_valid", rvB, ph == 7);
            if (ph == 7) chk("B_rd_data", rdDataB, 64'hD3D3_C2C2_B1B1_A0A0);
        end
        @(negedge clk);
        chk("B_null_idle", nullB, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
